// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, full-line fills over pmem.
// Define ICACHE_PERF_EN to add hit_count/miss_count performance counters.
module icache_dm #(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  imem_address,
    input  logic         imem_read,
    output logic [31:0]  imem_rdata,
    output logic         imem_resp,
    input  logic         invalidate,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int SETS = 2 ** S_INDEX;
    localparam int TAGW = 32 - S_OFFSET - S_INDEX;

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state_q, state_d;
    logic [31:0]         missAddr_q, missAddr_d;
    logic                discard_q, discard_d;
    logic [255:0]        data_q [SETS];
    logic [TAGW-1:0]     tag_q  [SETS];
    logic [SETS-1:0]     valid_q;

    logic [S_INDEX-1:0]  reqIndex, missIndex;
    logic [TAGW-1:0]     reqTag, missTag;
    logic                hit, fillDone;
    logic                addrLowBits_unused;

    assign reqIndex  = imem_address[S_OFFSET +: S_INDEX];
    assign reqTag    = imem_address[31 -: TAGW];
    assign missIndex = missAddr_q[S_OFFSET +: S_INDEX];
    assign missTag   = missAddr_q[31 -: TAGW];
    assign addrLowBits_unused = ^imem_address[1:0];

    assign hit = imem_read && valid_q[reqIndex] && (tag_q[reqIndex] == reqTag)
                 && (state_q == IDLE) && !invalidate;
    assign fillDone = (state_q == FILL) && pmem_resp;

    assign imem_resp  = hit;
    assign imem_rdata = data_q[reqIndex][{imem_address[4:2], 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            missAddr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            missAddr_q <= missAddr_d;
            discard_q  <= discard_d;
        end
    end

    // An invalidate seen at any point of a fill (including its last cycle) poisons that fill.
    always_comb begin
        state_d      = state_q;
        missAddr_d   = missAddr_q;
        discard_d    = discard_q;
        pmem_read    = 1'b0;
        pmem_address = '0;
        unique case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (imem_read && !hit && !invalidate) begin
                    state_d    = FILL;
                    missAddr_d = {imem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = missAddr_q;
                discard_d    = discard_q || invalidate;
                if (pmem_resp) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || invalidate) begin
            valid_q <= '0;
        end else if (fillDone && !discard_q) begin
            valid_q[missIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillDone) begin
            data_q[missIndex] <= pmem_rdata;
            tag_q[missIndex]  <= missTag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hitCount_q, missCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            if (imem_resp) begin
                hitCount_q <= hitCount_q + 32'd1;
            end
            if (state_q == IDLE && state_d == FILL) begin
                missCount_q <= missCount_q + 32'd1;
            end
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with a latency-configurable line memory model.
// Line memory content: word at byte address A is 0xA5000000 | A, except 0x6C which holds 0xDEADBEEF.
module tb_icache_dm;

    logic         clk;
    logic         rst;
    logic [31:0]  imem_address;
    logic         imem_read;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic         invalidate;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int memLat = 1;
    int memCnt = 0;
    logic injectResp = 1'b0;

    icache_dm #(.S_INDEX(4), .S_OFFSET(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .invalidate   (invalidate),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wordExp(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a == 32'h0000006C) return 32'hDEADBEEF;
        return 32'hA5000000 | a;
    endfunction

    function automatic logic [255:0] lineOf(input logic [31:0] addr);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[32*w +: 32] = wordExp({addr[31:5], 5'b0} + 32'(4 * w));
        end
        return l;
    endfunction

    // Memory model: acknowledges memLat cycles after it first sees pmem_read
    always @(posedge clk) begin
        pmem_resp <= 1'b0;
        if (injectResp) begin
            pmem_resp  <= 1'b1;
            pmem_rdata <= '1;
        end else if (pmem_read && !pmem_resp) begin
            if (memCnt + 1 >= memLat) begin
                pmem_resp  <= 1'b1;
                pmem_rdata <= lineOf(pmem_address);
                memCnt     <= 0;
            end else begin
                memCnt <= memCnt + 1;
            end
        end else if (!pmem_read) begin
            memCnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic inv);
        imem_address = addr;
        imem_read    = rd;
        invalidate   = inv;
        #1;
    endtask

    // Holds a fetch until it is answered; a miss costs memLat+2 cycles, a hit none.
    task automatic fetchExpect(input string tag, input logic [31:0] addr, input bit expMiss);
        int n;
        applyStimulus(addr, 1'b1, 1'b0);
        n = 0;
        while (!imem_resp && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_lat"}, 32'(n), expMiss ? 32'(memLat + 2) : 32'd0);
        checkOutput({tag, "_data"}, imem_rdata, wordExp(addr));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rst_resp", 32'(imem_resp), 32'd0);
        checkOutput("rst_pread", 32'(pmem_read), 32'd0);
        checkOutput("rst_paddr", pmem_address, 32'h0);
`ifdef ICACHE_PERF_EN
        checkOutput("rst_hits", hit_count, 32'd0);
        checkOutput("rst_misses", miss_count, 32'd0);
`endif
        rst = 1'b0;
        stepCycle();

        // Cold miss on the line at 0x60, word 3
        memLat = 1;
        applyStimulus(32'h0000006C, 1'b1, 1'b0);
        checkOutput("cold_c0_resp", 32'(imem_resp), 32'd0);
        checkOutput("cold_c0_pread", 32'(pmem_read), 32'd0);
        stepCycle();
        checkOutput("cold_c1_pread", 32'(pmem_read), 32'd1);
        checkOutput("cold_c1_paddr", pmem_address, 32'h00000060);
        checkOutput("cold_c1_resp", 32'(imem_resp), 32'd0);
        stepCycle();
        checkOutput("cold_c2_resp", 32'(imem_resp), 32'd0);
        stepCycle();
        checkOutput("cold_c3_resp", 32'(imem_resp), 32'd1);
        checkOutput("cold_c3_data", imem_rdata, 32'hDEADBEEF);
        checkOutput("cold_c3_pread", 32'(pmem_read), 32'd0);
        stepCycle();
        applyStimulus(32'h00000064, 1'b1, 1'b0);
        checkOutput("hit64_resp", 32'(imem_resp), 32'd1);
        checkOutput("hit64_data", imem_rdata, 32'hA5000064);
        checkOutput("hit64_pread", 32'(pmem_read), 32'd0);
        stepCycle();
`ifdef ICACHE_PERF_EN
        checkOutput("perf_hits", hit_count, 32'd2);
        checkOutput("perf_misses", miss_count, 32'd1);
`endif
        applyStimulus(32'h00000064, 1'b0, 1'b0);
        checkOutput("noread_resp", 32'(imem_resp), 32'd0);
        stepCycle();
        checkOutput("noread_pread", 32'(pmem_read), 32'd0);

        // Conflict on index 0
        fetchExpect("conf000", 32'h00000004, 1'b1);
        fetchExpect("conf200", 32'h00000208, 1'b1);
        fetchExpect("conf000b", 32'h0000001C, 1'b1);
        fetchExpect("keep060", 32'h00000068, 1'b0);

        // Address change while the fill for 0x100 stalls
        memLat = 5;
        applyStimulus(32'h00000100, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(32'h00000300, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            checkOutput($sformatf("mid_c%0d_paddr", k), pmem_address, 32'h00000100);
            checkOutput($sformatf("mid_c%0d_resp", k), 32'(imem_resp), 32'd0);
            stepCycle();
        end
        checkOutput("mid_idle_resp", 32'(imem_resp), 32'd0);
        stepCycle();
        checkOutput("mid_second_paddr", pmem_address, 32'h00000300);
        n = 1;
        while (!imem_resp && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput("mid_second_lat", 32'(n), 32'd7);
        checkOutput("mid_second_data", imem_rdata, 32'hA5000300);

        // Invalidate during the fill of 0x40
        memLat = 3;
        applyStimulus(32'h00000040, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(32'h00000040, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(32'h00000040, 1'b0, 1'b0);
        n = 0;
        while (pmem_read && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("invfill_done", 32'(n), 32'd3);
        stepCycle();
        checkOutput("invfill_nofill", 32'(pmem_read), 32'd0);
        fetchExpect("invfill40", 32'h00000040, 1'b1);
        fetchExpect("invfill00", 32'h00000000, 1'b1);

        // Invalidate while idle masks a hit and starts no fill
        applyStimulus(32'h00000000, 1'b1, 1'b1);
        checkOutput("invidle_resp", 32'(imem_resp), 32'd0);
        stepCycle();
        checkOutput("invidle_pread", 32'(pmem_read), 32'd0);
        fetchExpect("invidle00", 32'h00000000, 1'b1);

        // Invalidate coinciding with pmem_resp
        memLat = 1;
        applyStimulus(32'h00000080, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        applyStimulus(32'h00000080, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(32'h00000080, 1'b0, 1'b0);
        checkOutput("samecyc_pread", 32'(pmem_read), 32'd0);
        fetchExpect("samecyc80", 32'h00000080, 1'b1);

        // Reset during a long fill, followed by a stray acknowledge
        memLat = 50;
        applyStimulus(32'h000000C0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("rstfill_pread", 32'(pmem_read), 32'd1);
        checkOutput("rstfill_paddr", pmem_address, 32'h000000C0);
        rst = 1'b1;
        applyStimulus(32'h000000C0, 1'b0, 1'b0);
        stepCycle();
        rst = 1'b0;
        checkOutput("rstfill_drop", 32'(pmem_read), 32'd0);
        checkOutput("rstfill_paddr0", pmem_address, 32'h0);
        injectResp = 1'b1;
        stepCycle();
        injectResp = 1'b0;
        stepCycle();
        checkOutput("late_pread", 32'(pmem_read), 32'd0);
        checkOutput("late_resp", 32'(imem_resp), 32'd0);
        memLat = 1;
        fetchExpect("rstC0", 32'h000000C0, 1'b1);
        fetchExpect("rst80", 32'h00000084, 1'b1);

        applyStimulus(32'h0, 1'b0, 1'b0);
        stepCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
